// File: rtl/proc_defs_pkg.sv
// Shared encodings for the main sequencer and control_unit: state codes, opcodes and their widths.
// control_unit imports this same package, so these codes are defined in one place only.
package proc_defs_pkg;

    localparam int STATE_W = 6;
    localparam int OPC_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 6'd0,
        S_FETCH1 = 6'd1,
        S_FETCH2 = 6'd2,
        S_FETCH3 = 6'd3,
        S_FETCH4 = 6'd4,
        S_FETCH5 = 6'd5,
        S_FETCH6 = 6'd6,
        S_LDR11  = 6'd7,
        S_LDR12  = 6'd8,
        S_LDR13  = 6'd9,
        S_LDR14  = 6'd10,
        S_LDR21  = 6'd11,
        S_LDR22  = 6'd12,
        S_LDR23  = 6'd13,
        S_LDR24  = 6'd14,
        S_STAC1  = 6'd15,
        S_STAC2  = 6'd16,
        S_STAC3  = 6'd17,
        S_STAC4  = 6'd18,
        S_ADD    = 6'd19,
        S_ADD2   = 6'd20,
        S_MUL    = 6'd21
    } seq_state_e;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LDR1 = 4'd1,
        OP_LDR2 = 4'd2,
        OP_STAC = 4'd3,
        OP_ADD  = 4'd4,
        OP_MUL  = 4'd5,
        OP_HALT = 4'd15
    } opcode_e;

endpackage

// File: rtl/seq_opcode_decode.sv
// Combinational opcode map: the state entered on leaving fetch6, plus legal/halt flags.
module seq_opcode_decode
    import proc_defs_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    output logic [STATE_W-1:0] first_state,
    output logic               is_legal,
    output logic               is_halt
);

    always_comb begin
        first_state = S_FETCH1;
        is_legal    = 1'b1;
        is_halt     = 1'b0;
        case (opcode)
            OP_NOP:  first_state = S_FETCH1;
            OP_LDR1: first_state = S_LDR11;
            OP_LDR2: first_state = S_LDR21;
            OP_STAC: first_state = S_STAC1;
            OP_ADD:  first_state = S_ADD;
            OP_MUL:  first_state = S_MUL;
            OP_HALT: begin
                first_state = S_IDLE;
                is_halt     = 1'b1;
            end
            // Undefined opcodes skip execute and go straight back to fetch.
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Main-FSM sequencer: fetch, decode, execute; drives the state code seen by control_unit.
// State/opcode widths come from the shared package so they always agree with control_unit.
module instr_sequencer
    import proc_defs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic [OPC_W-1:0]   ir_opcode,
    output logic [STATE_W-1:0] state,
    output logic               done,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    logic [STATE_W-1:0] dec_state;
    logic               dec_legal;
    logic               dec_halt;

    logic [STATE_W-1:0] next_state;
    logic               retire;
    logic               done_next;
    logic               illegal_next;

    seq_opcode_decode u_decode (
        .opcode      (ir_opcode),
        .first_state (dec_state),
        .is_legal    (dec_legal),
        .is_halt     (dec_halt)
    );

    always_comb begin
        next_state   = state;
        retire       = 1'b0;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        if (!stall) begin
            case (state)
                S_IDLE: if (start) next_state = S_FETCH1;
                S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_FETCH5,
                S_LDR11, S_LDR12, S_LDR13,
                S_LDR21, S_LDR22, S_LDR23,
                S_STAC1, S_STAC2, S_STAC3:
                    next_state = state + STATE_W'(1);
                S_FETCH6: begin
                    next_state   = dec_state;
                    retire       = 1'b1;
                    done_next    = dec_halt;
                    illegal_next = !dec_legal;
                end
                S_ADD:  next_state = S_ADD2;
                S_LDR14, S_LDR24, S_STAC4, S_ADD2, S_MUL:
                    next_state = S_FETCH1;
                // Unused codes recover to idle and flag it.
                default: begin
                    next_state   = S_IDLE;
                    illegal_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state   <= next_state;
            done    <= done_next;
            illegal <= illegal_next;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle expectations queued on a scoreboard, checked on the falling edge.
// Counter width is reduced so the wrap case can be reached with a short run of NOPs.
module tb_instr_sequencer;

    localparam int CNT_W = 8;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             stall;
    logic [3:0]       ir_opcode;
    logic [5:0]       state;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    typedef struct {
        logic [5:0]       st;
        logic             dn;
        logic             il;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               vectors;
    int               errors;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .ir_opcode   (ir_opcode),
        .state       (state),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, got time %0t, required < 400000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        vectors += 4;
        assert (state === e.st) else begin
            errors++; $error("FAIL state: got %0d, required %0d at %0t", state, e.st, $time);
        end
        assert (done === e.dn) else begin
            errors++; $error("FAIL done: got %b, required %b at %0t", done, e.dn, $time);
        end
        assert (illegal === e.il) else begin
            errors++; $error("FAIL illegal: got %b, required %b at %0t", illegal, e.il, $time);
        end
        assert (instr_count === e.cnt) else begin
            errors++; $error("FAIL instr_count: got %0d, required %0d at %0t", instr_count, e.cnt, $time);
        end
    endtask

    // Expectation for the state after the next rising edge.
    task automatic step(input logic [5:0] st, input logic dn, input logic il);
        sb.push_back('{st: st, dn: dn, il: il, cnt: exp_cnt});
        @(posedge clock);
        @(negedge clock);
        check_front();
    endtask

    // Expectation checked immediately, with no clock edge in between.
    task automatic now_chk(input logic [5:0] st, input logic dn, input logic il);
        sb.push_back('{st: st, dn: dn, il: il, cnt: exp_cnt});
        check_front();
    endtask

    // From fetch1: walk fetch2..fetch6 with the opcode presented; the next edge retires it.
    task automatic fetch(input logic [3:0] opc);
        ir_opcode = opc;
        for (int s = 2; s <= 6; s++) step(6'(s), 1'b0, 1'b0);
        exp_cnt++;
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        exp_cnt   = '0;
        reset_n   = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        ir_opcode = 4'd0;

        #2 reset_n = 1'b0;
        #1 now_chk(6'd0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(6'd0, 1'b0, 1'b0);

        // LDR1
        start = 1'b1;
        ir_opcode = 4'd1;
        step(6'd1, 1'b0, 1'b0);
        start = 1'b0;
        fetch(4'd1);
        step(6'd7, 1'b0, 1'b0);
        step(6'd8, 1'b0, 1'b0);
        step(6'd9, 1'b0, 1'b0);
        step(6'd10, 1'b0, 1'b0);
        step(6'd1, 1'b0, 1'b0);

        // LDR2, ADD, MUL
        fetch(4'd2);
        for (int s = 11; s <= 14; s++) step(6'(s), 1'b0, 1'b0);
        step(6'd1, 1'b0, 1'b0);
        fetch(4'd4);
        step(6'd19, 1'b0, 1'b0);
        step(6'd20, 1'b0, 1'b0);
        step(6'd1, 1'b0, 1'b0);
        fetch(4'd5);
        step(6'd21, 1'b0, 1'b0);
        step(6'd1, 1'b0, 1'b0);

        // STAC with a 3-cycle stall in stac2
        fetch(4'd3);
        step(6'd15, 1'b0, 1'b0);
        step(6'd16, 1'b0, 1'b0);
        stall = 1'b1;
        step(6'd16, 1'b0, 1'b0);
        step(6'd16, 1'b0, 1'b0);
        step(6'd16, 1'b0, 1'b0);
        stall = 1'b0;
        step(6'd17, 1'b0, 1'b0);
        step(6'd18, 1'b0, 1'b0);
        step(6'd1, 1'b0, 1'b0);

        // Illegal opcode, then NOP, then HALT
        fetch(4'd9);
        step(6'd1, 1'b0, 1'b1);
        fetch(4'd0);
        step(6'd1, 1'b0, 1'b0);
        fetch(4'd15);
        step(6'd0, 1'b1, 1'b0);
        step(6'd0, 1'b0, 1'b0);

        // Stall beats start in idle
        stall = 1'b1;
        start = 1'b1;
        step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        stall = 1'b0;
        step(6'd1, 1'b0, 1'b0);
        start = 1'b0;

        // Start during the done cycle relaunches fetch immediately
        fetch(4'd15);
        start = 1'b1;
        step(6'd0, 1'b1, 1'b0);
        step(6'd1, 1'b0, 1'b0);
        start = 1'b0;

        // Reset mid-ldr12 aborts before the next edge
        fetch(4'd1);
        step(6'd7, 1'b0, 1'b0);
        step(6'd8, 1'b0, 1'b0);
        reset_n = 1'b0;
        exp_cnt = '0;
        #1 now_chk(6'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step(6'd0, 1'b0, 1'b0);

        // Counter wrap: 2^CNT_W-1 NOPs, then one more retire wraps to 0
        start = 1'b1;
        step(6'd1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            fetch(4'd0);
            step(6'd1, 1'b0, 1'b0);
        end
        vectors++;
        assert (instr_count === {CNT_W{1'b1}}) else begin
            errors++; $error("FAIL count_max: got %0d, required %0d", instr_count, {CNT_W{1'b1}});
        end
        fetch(4'd0);
        step(6'd1, 1'b0, 1'b0);

        // Unused state code recovers to idle with illegal flagged
        force dut.state = 6'd30;
        #1 release dut.state;
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
